// File: rtl/stack_pkg.sv
// Shared types and constants for the stack machine memory responder.
package stack_pkg;

  localparam int unsigned DATA_W = 8;

  // Core write-bus value that arms a store on the following cycle.
  localparam logic [DATA_W-1:0] STORE_MARKER_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    RUN_IDLE  = 2'd1,
    RUN_ARMED = 2'd2
  } resp_state_e;

endpackage

// File: rtl/byte_ram.sv
// Byte-wide flop array: one synchronous write port with bulk clear, one asynchronous read port.
module byte_ram
  import stack_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              clear_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];

  // Clear takes priority over any same-cycle write.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Reads see the pre-edge contents, so a write is visible from the next cycle.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stack_mem_responder.sv
// Memory-side responder: program loader, two-beat store decoder and combinational read port.
module stack_mem_responder
  import stack_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 8,
  parameter logic [DATA_W-1:0] STORE_MARKER   = STORE_MARKER_DEFAULT,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        cpu_mem_addr,
  input  logic [DATA_W-1:0] cpu_data_out,
  output logic [DATA_W-1:0] cpu_data_in,
  output logic              cpu_reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [7:0]        ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              wr_strobe
);

  resp_state_e       state_q, state_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_clear;

  // State and registered outputs; reset abandons any armed store.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= LOAD;
      cpu_reset_q <= 1'b1;
      wr_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpu_reset_q <= cpu_reset_d;
      wr_strobe_q <= wr_strobe_d;
    end
  end

  // Next state: loader exits on its last beat, store protocol alternates idle/armed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD: begin
        if (ld_valid && ld_last) state_d = RUN_IDLE;
      end
      RUN_IDLE: begin
        if (cpu_data_out == STORE_MARKER) state_d = RUN_ARMED;
      end
      RUN_ARMED: state_d = RUN_IDLE;
      default:   state_d = LOAD;
    endcase
    // Core is released on the same edge that accepts the final load beat.
    cpu_reset_d = (state_d == LOAD);
    wr_strobe_d = (state_q == RUN_ARMED);
  end

  // Outputs and write-port mux: loader owns the port in LOAD, the core in the commit beat.
  always_comb begin
    ld_ready  = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = cpu_mem_addr[ADDR_W-1:0];
    ram_wdata = cpu_data_out;
    unique case (state_q)
      LOAD: begin
        ld_ready  = 1'b1;
        ram_we    = ld_valid;
        ram_waddr = ld_addr[ADDR_W-1:0];
        ram_wdata = ld_data;
      end
      RUN_ARMED: ram_we = 1'b1;
      default: ;
    endcase
    if (reset) ram_we = 1'b0;
  end

  assign ram_clear = reset && CLEAR_ON_RESET;

  byte_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk_i  (clock),
    .clear_i(ram_clear),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .raddr_i(cpu_mem_addr[ADDR_W-1:0]),
    .rdata_o(cpu_data_in)
  );

  assign cpu_reset = cpu_reset_q;
  assign wr_strobe = wr_strobe_q;

endmodule
